// File: rtl/add_accumulator_if.sv
// Handshake bundle for add_accumulator: burst start, operand stream in, total out.
interface add_accumulator_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned ACC_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, acc, ovf, busy
    );

    modport slave (
        input  start, len, in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, acc, ovf, busy
    );
endinterface

// File: rtl/add_accumulator.sv
// Sums a burst of {a, b, cin} triples into a wrapping accumulator with a sticky
// carry-out flag, then offers the total on an output handshake.
module add_accumulator #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    add_accumulator_if.slave   bus
);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [ACC_W-1:0] acc_q, acc_n;
    logic             ovf_q, ovf_n;
    logic [LEN_W-1:0] rem_q, rem_n;
    logic             in_ready_q, in_ready_n;
    logic             out_valid_q, out_valid_n;
    logic             busy_q, busy_n;
    logic [SUM_W-1:0] sum_c;

    // One extra bit on the sum captures the carry out of the accumulator.
    assign sum_c = {1'b0, acc_q} + SUM_W'(bus.a) + SUM_W'(bus.b) + SUM_W'(bus.cin);

    always_comb begin
        state_n = state_q;
        acc_n   = acc_q;
        ovf_n   = ovf_q;
        rem_n   = rem_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_n   = '0;
                    ovf_n   = 1'b0;
                    rem_n   = bus.len;
                    state_n = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_n = sum_c[ACC_W-1:0];
                    ovf_n = ovf_q | sum_c[ACC_W];
                    rem_n = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready && out_valid_q) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Handshake flags follow the next state so they register alongside it.
        in_ready_n  = (state_n == ACCUM);
        out_valid_n = (state_n == DONE);
        busy_n      = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            acc_q       <= acc_n;
            ovf_q       <= ovf_n;
            rem_q       <= rem_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc       = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/add_accumulator.md
Name: add_accumulator

Overview:
- Sequential stage directly downstream of the team's ripple-carry adder datapath.
- Consumes a burst of operand triples {a, b, cin} over a valid/ready handshake and sums each triple into a running accumulator.
- Presents the final total and a sticky overflow flag on an output valid/ready handshake.
- Used wherever multi-operand totals of narrow adder results are required.

Parameters:
- WIDTH, 3: width of operands a and b.
- LEN_W, 4: width of the burst-length field; a burst holds up to 2^LEN_W-1 operand triples.
- ACC_W, 8: accumulator width; must be at least WIDTH+1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin burst; sampled only in IDLE.
- len  input  LEN_W  number of operand triples in the burst; sampled with start.
- in_valid  input  1  operand triple valid.
- in_ready  output  1  block accepts an operand triple this cycle.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- cin  input  1  carry-in for this triple.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- acc  output  ACC_W  accumulated total (registered).
- ovf  output  1  sticky: the accumulator carried out of ACC_W during this burst.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- States and outputs:
  - IDLE: in_ready=0, out_valid=0, busy=0.
  - ACCUM: in_ready=1, out_valid=0, busy=1.
  - DONE: in_ready=0, out_valid=1, busy=1.
- Reset: rst=1 at a clock edge forces IDLE, acc=0, ovf=0, the remaining-count register to 0, and all handshake outputs to 0. This applies from any state, including mid-burst; any partial total is discarded.
- IDLE, start=1 with len!=0: next cycle enters ACCUM; acc=0, ovf=0, remaining=len.
- IDLE, start=1 with len==0: next cycle enters DONE with acc=0, ovf=0.
- IDLE, start=0: stays in IDLE; acc and ovf hold the last result.
- ACCUM, transfer on in_valid&&in_ready:
  - Zero-extend a, b and cin to ACC_W+1 bits.
  - sum = acc + a + b + cin.
  - acc <= sum[ACC_W-1:0]; the result wraps modulo 2^ACC_W.
  - ovf <= ovf | sum[ACC_W].
  - remaining decrements by 1.
  - If remaining was 1, the next state is DONE.
- ACCUM, in_valid=0: no change; gaps of any length are allowed.
- Latency: the updated acc is visible on the cycle after the transfer. out_valid rises on the cycle after the final transfer.
- DONE: acc and ovf are held stable while out_valid=1 and out_ready=0. On out_valid&&out_ready, the next state is IDLE; acc and ovf keep their values.
- start is ignored outside IDLE. len is sampled only on the accepting start cycle.
- a, b and cin are don't-care when the transfer condition is false.
- The block is purely synchronous, with no combinational path from any input to any output.

Test Plan:
- Basic burst (defaults): start, len=2; send (a=3,b=4,cin=0), then (7,7,1); out_ready=1 -> out_valid one cycle after the 2nd transfer, acc=22, ovf=0, then return to IDLE.
- Wrap/overflow (ACC_W=5): len=3, three transfers of (7,7,1) -> acc=13 (45 mod 32), ovf=1. A following burst len=1 with (1,0,0) -> acc=1, ovf=0.
- Backpressure and gaps: len=3 with in_valid toggled 1,0,0,1,0,1 -> exactly 3 accepts; hold out_ready=0 for 5 cycles -> out_valid, acc and ovf stable throughout; out_ready=1 -> IDLE next cycle.
- Zero length: start, len=0 -> DONE next cycle, acc=0, in_ready never asserted.
- Reset mid-burst: len=4, two transfers of (7,7,1), then rst=1 for one cycle -> IDLE, acc=0, ovf=0, busy=0; a new burst len=1 with (2,2,0) -> acc=4.
- Start while busy: pulse start with len=9 during ACCUM of a len=2 burst -> ignored, and the burst ends after exactly 2 transfers.
